// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Purpose  : N-channel, WIDTH-bit registered multiplexer with built-in
//            arbitration (round-robin or fixed lowest-index priority) and a
//            valid/ready handshake on every input and on the output.
//            The chosen word and its source index land in a one-entry
//            output register. The register refills in the same cycle it
//            drains, so throughput is one word per cycle.
// Ports    : clk       - clock, all state updates on the rising edge
//            reset     - synchronous, active-high reset
//            in_data   - N packed channels, channel i at [i*WIDTH +: WIDTH]
//            in_valid  - per-channel word-present flags
//            in_ready  - per-channel accept strobe (one-hot or zero)
//            out_data  - registered selected word
//            out_src   - index of the channel that supplied out_data
//            out_valid - output register holds a word
//            out_ready - consumer takes the word this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   parameter  int MODE  = 0,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_src,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam logic [SEL_W-1:0] c_LAST_IDX = SEL_W'(N - 1);

   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_src;
   logic             r_out_valid;
   logic [SEL_W-1:0] r_ptr;

   logic             w_accept;
   logic [N-1:0]     w_hi;
   logic [N-1:0]     w_pick;
   logic             w_any;
   logic [SEL_W-1:0] w_gnt_idx;
   logic [N-1:0]     w_gnt_oh;
   logic [WIDTH-1:0] w_word;
   logic             w_xfer_in;
   logic [SEL_W-1:0] w_ptr_nxt;

   // The register can take a new word when it is empty or drains this cycle.
   assign w_accept = ~r_out_valid | out_ready;

   // Round-robin is done as a two-level priority search: requesters at or
   // above the pointer are tried first; if there are none, the lowest
   // requester overall wins, which gives the wrap-around. Fixed priority
   // simply skips the upper-half mask.
   generate
      if (MODE == 0) begin : g_rr_mask
         always_comb begin
            w_hi = '0;
            for (int i = 0; i < N; i++) begin
               w_hi[i] = in_valid[i] && (i >= int'(r_ptr));
            end
         end
      end else begin : g_fixed_mask
         assign w_hi = '0;
      end
   endgenerate

   assign w_pick = (|w_hi) ? w_hi : in_valid;
   assign w_any  = |in_valid;

   // Lowest set bit of w_pick; scanning downward lets the lowest index
   // overwrite any higher one.
   always_comb begin
      w_gnt_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_pick[i]) begin
            w_gnt_idx = SEL_W'(i);
         end
      end
   end

   always_comb begin
      w_gnt_oh = '0;
      w_word   = '0;
      for (int i = 0; i < N; i++) begin
         w_gnt_oh[i] = w_any && (SEL_W'(i) == w_gnt_idx);
         w_word      = w_word | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt_oh[i]}});
      end
   end

   assign in_ready  = w_gnt_oh & {N{w_accept & ~reset}};
   assign w_xfer_in = w_any & w_accept;
   assign w_ptr_nxt = (w_gnt_idx == c_LAST_IDX) ? '0 : w_gnt_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= '0;
      end else if (w_xfer_in) begin
         r_out_data  <= w_word;
         r_out_src   <= w_gnt_idx;
         r_out_valid <= 1'b1;
         if (MODE == 0) begin
            r_ptr <= w_ptr_nxt;
         end
      end else if (out_ready) begin
         // Drain with nothing to refill: data and source hold their values.
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Purpose  : Directed, self-checking bench for rr_mux_arbiter. A round-robin
//            instance and a fixed-priority instance share the same stimulus.
//            Inputs change on the falling edge; outputs are sampled 1 ns
//            later, well away from the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

   localparam int WIDTH = 32;
   localparam int N     = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic               out_ready;

   logic [N-1:0]       rr_in_ready, fp_in_ready;
   logic [WIDTH-1:0]   rr_out_data, fp_out_data;
   logic [1:0]         rr_out_src,  fp_out_src;
   logic               rr_out_valid, fp_out_valid;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.WIDTH(WIDTH), .N(N), .MODE(0)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (rr_in_ready),
      .out_data  (rr_out_data),
      .out_src   (rr_out_src),
      .out_valid (rr_out_valid),
      .out_ready (out_ready)
   );

   rr_mux_arbiter #(.WIDTH(WIDTH), .N(N), .MODE(1)) u_fp (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (fp_in_ready),
      .out_data  (fp_out_data),
      .out_src   (fp_out_src),
      .out_valid (fp_out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [31:0] e_d;
      logic [1:0]  e_s;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_default_data();
      for (int i = 0; i < N; i++) begin
         in_data[i*WIDTH +: WIDTH] = 32'hA0 + i;
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = 1'b0;
      set_default_data();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = 1'b0;
      in_data   = '0;

      // Each row: inputs for the cycle, in_ready expected in that cycle,
      // and out_* expected from the previous rising edge.
      //           rst  valid   ordy  e_rdy   ov  data    src
      tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 32'h00, 2'd0};
      tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 32'h00, 2'd0};
      tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'hA0, 2'd0};
      tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'hA1, 2'd1};
      tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'hA2, 2'd2};
      tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'hA3, 2'd3};
      tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'hA0, 2'd0};
      tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'hA1, 2'd1};
      tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'hA2, 2'd2};
      tbl[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'hA3, 2'd3};
      // idle drain happened; now grant ch1 to leave the pointer at 2
      tbl[10] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0, 32'hA3, 2'd3};
      // pointer 2, only ch0/ch1 valid: wrap-around grants ch0
      tbl[11] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, 32'hA1, 2'd1};
      tbl[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'hA0, 2'd0};
      tbl[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'hA0, 2'd0};
      tbl[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'hA0, 2'd0};

      @(negedge clk);
      do_reset();

      for (int r = 0; r < 15; r++) begin
         reset     = tbl[r].rst;
         in_valid  = tbl[r].v;
         out_ready = tbl[r].ordy;
         #1;
         chk($sformatf("tbl%0d in_ready", r),  32'(rr_in_ready),  32'(tbl[r].e_rdy));
         chk($sformatf("tbl%0d out_valid", r), 32'(rr_out_valid), 32'(tbl[r].e_ov));
         chk($sformatf("tbl%0d out_data", r),  rr_out_data,       tbl[r].e_d);
         chk($sformatf("tbl%0d out_src", r),   32'(rr_out_src),   32'(tbl[r].e_s));
         @(negedge clk);
      end

      // ---- Backpressure: latch 0x55, stall, then drain+accept together ----
      do_reset();
      in_data[0 +: WIDTH] = 32'h55;
      in_valid  = 4'b0001;
      out_ready = 1'b0;
      #1;
      chk("bp load in_ready", 32'(rr_in_ready), 32'h1);
      @(negedge clk);
      set_default_data();
      for (int c = 0; c < 3; c++) begin
         in_valid  = 4'b0100;
         out_ready = 1'b0;
         #1;
         chk($sformatf("bp stall%0d in_ready", c), 32'(rr_in_ready), 32'h0);
         chk($sformatf("bp stall%0d out_data", c), rr_out_data, 32'h55);
         chk($sformatf("bp stall%0d out_valid", c), 32'(rr_out_valid), 32'h1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 32'(rr_in_ready), 32'h4);
      chk("bp release out_data", rr_out_data, 32'h55);
      @(negedge clk);
      in_valid = 4'b0000;
      #1;
      chk("bp next out_data",  rr_out_data, 32'hA2);
      chk("bp next out_src",   32'(rr_out_src), 32'h2);
      chk("bp next out_valid", 32'(rr_out_valid), 32'h1);
      @(negedge clk);

      // ---- Fixed priority: ch1 wins every cycle over ch2/ch3 ----
      do_reset();
      for (int c = 0; c < 3; c++) begin
         in_valid  = 4'b1110;
         out_ready = 1'b1;
         #1;
         chk($sformatf("fp cyc%0d in_ready", c), 32'(fp_in_ready), 32'h2);
         if (c > 0) begin
            chk($sformatf("fp cyc%0d out_src", c),  32'(fp_out_src), 32'h1);
            chk($sformatf("fp cyc%0d out_data", c), fp_out_data, 32'hA1);
         end
         @(negedge clk);
      end
      in_valid = 4'b0000;
      #1;
      chk("fp last out_src",   32'(fp_out_src), 32'h1);
      chk("fp last out_valid", 32'(fp_out_valid), 32'h1);
      @(negedge clk);

      // ---- Reset mid-operation with pointer at 3 ----
      do_reset();
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("mid pre out_src", 32'(rr_out_src), 32'h2);
      reset = 1'b1;
      #1;
      chk("mid rst in_ready", 32'(rr_in_ready), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid post out_valid", 32'(rr_out_valid), 32'h0);
      chk("mid post out_data",  rr_out_data, 32'h0);
      chk("mid post out_src",   32'(rr_out_src), 32'h0);
      chk("mid post in_ready",  32'(rr_in_ready), 32'h1);
      @(negedge clk);
      #1;
      chk("mid grant out_src",  32'(rr_out_src), 32'h0);
      chk("mid grant out_data", rr_out_data, 32'hA0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
